// File: rtl/pc_sequencer.sv
// Multicycle PC fetch/redirect controller: FETCH -> ISSUE -> EXEC, one instruction
// in flight, sticky FAULT on fetch timeout or misaligned next PC.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_resolve,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump_valid,
  input  logic [31:0] i_jump_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_retired,
  output logic        o_fault,
  output logic [1:0]  o_fault_code
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_EXEC, S_FAULT} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr, r_retired;
  logic [7:0]  r_cnt;
  logic [1:0]  r_fault_code;

  logic [31:0] w_pc_plus4, w_next_pc;
  logic        w_ack, w_timeout, w_issue, w_resolve, w_misaligned;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_next_pc    = i_jump_valid   ? i_jump_target :
                        i_branch_taken ? w_pc_plus4 + i_branch_offset : w_pc_plus4;
  assign w_ack        = (r_state == S_FETCH) && i_imem_ack;
  // An ack in the last allowed cycle takes priority over the timeout.
  assign w_timeout    = (r_state == S_FETCH) && !i_imem_ack && (r_cnt == LP_LAST);
  assign w_issue      = (r_state == S_ISSUE) && i_instr_ready && !i_stall;
  assign w_resolve    = (r_state == S_EXEC) && i_resolve && !i_stall;
  assign w_misaligned = |w_next_pc[1:0];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (w_ack) w_next_state = S_ISSUE;
               else if (w_timeout) w_next_state = S_FAULT;
      S_ISSUE: if (w_issue) w_next_state = S_EXEC;
      S_EXEC:  if (w_resolve) w_next_state = w_misaligned ? S_FAULT : S_FETCH;
      default: w_next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_VECTOR;
      r_instr      <= '0;
      r_retired    <= '0;
      r_cnt        <= '0;
      r_fault_code <= 2'b00;
    end else begin
      r_state <= w_next_state;
      if (w_ack) r_instr <= i_imem_rdata;
      if (r_state == S_FETCH && !i_imem_ack) r_cnt <= r_cnt + 8'd1;
      else                                   r_cnt <= '0;
      // The faulting address is committed so it is observable on o_pc.
      if (w_resolve) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
        if (w_misaligned) r_fault_code <= 2'b10;
      end
      if (w_timeout) r_fault_code <= 2'b01;
    end
  end

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_retired     = r_retired;
  assign o_fault       = (r_state == S_FAULT);
  assign o_fault_code  = r_fault_code;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per scenario, inline checks.
module tb_pc_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic        i_resolve = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_offset = '0;
  logic        i_jump_valid = 1'b0;
  logic [31:0] i_jump_target = '0;
  logic [31:0] o_pc, o_pc_plus4, o_retired;
  logic        o_fault;
  logic [1:0]  o_fault_code;

  int n_chk = 0;
  int n_fail = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr), .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .i_resolve(i_resolve), .i_branch_taken(i_branch_taken), .i_branch_offset(i_branch_offset),
    .i_jump_valid(i_jump_valid), .i_jump_target(i_jump_target),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_retired(o_retired),
    .o_fault(o_fault), .o_fault_code(o_fault_code)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: instruction word is a tag of the requested address.
  always_comb i_imem_rdata = 32'hC0DE_0000 ^ o_imem_addr;

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_imem_ack = 1'b0; i_instr_ready = 1'b0; i_resolve = 1'b0;
    i_stall = 1'b0; i_jump_valid = 1'b0; i_branch_taken = 1'b0;
    #2;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_ack = 1'b1; i_instr_ready = 1'b1; i_resolve = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    n_chk++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h0); end
    n_chk++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got=%b exp=1", o_imem_req); end
    n_chk++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_instr_valid); end
    n_chk++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
    n_chk++; if (o_retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", o_retired); end
    n_chk++; if (o_fault !== 1'b0 || o_fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_fault got=%b/%b exp=0/00", o_fault, o_fault_code); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_ack = 1'b1; i_instr_ready = 1'b1; i_resolve = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4*k)) begin n_fail++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", k, o_imem_req, o_imem_addr, 32'(4*k)); end
      step();
      n_chk++; if (o_instr_valid !== 1'b1 || o_instr !== (32'hC0DE_0000 ^ 32'(4*k))) begin n_fail++; $display("FAIL seq_issue%0d got=%b/%h exp=1/%h", k, o_instr_valid, o_instr, 32'hC0DE_0000 ^ 32'(4*k)); end
      step();
      n_chk++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_exec%0d got=%b/%b exp=0/0", k, o_instr_valid, o_imem_req); end
      step();
    end
    n_chk++; if (o_retired !== 32'd4) begin n_fail++; $display("FAIL seq_retired got=%0d exp=4", o_retired); end
    n_chk++; if (o_pc !== 32'h10 || o_pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL seq_pc got=%h/%h exp=10/14", o_pc, o_pc_plus4); end
  endtask

  task automatic test_branch_jump();
    step(); step();
    i_jump_valid = 1'b1; i_jump_target = 32'h100;
    step();
    i_jump_valid = 1'b0;
    n_chk++; if (o_imem_addr !== 32'h100) begin n_fail++; $display("FAIL bj_setup got=%h exp=100", o_imem_addr); end
    step(); step();
    i_branch_taken = 1'b1; i_branch_offset = 32'h20;
    step();
    i_branch_taken = 1'b0;
    n_chk++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h124) begin n_fail++; $display("FAIL bj_branch got=%b/%h exp=1/124", o_imem_req, o_imem_addr); end
    step(); step();
    i_jump_valid = 1'b1; i_branch_taken = 1'b1; i_jump_target = 32'h40;
    step();
    i_jump_valid = 1'b0; i_branch_taken = 1'b0;
    n_chk++; if (o_imem_addr !== 32'h40) begin n_fail++; $display("FAIL bj_jump_prio got=%h exp=40", o_imem_addr); end
    n_chk++; if (o_retired !== 32'd7) begin n_fail++; $display("FAIL bj_retired got=%0d exp=7", o_retired); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    i_instr_ready = 1'b0;
    step();
    held = 32'hC0DE_0040;
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (o_instr_valid !== 1'b1 || o_instr !== held || o_pc !== 32'h40) begin n_fail++; $display("FAIL bp_issue%0d got=%b/%h/%h exp=1/%h/40", c, o_instr_valid, o_instr, o_pc, held); end
      step();
    end
    i_instr_ready = 1'b1; i_stall = 1'b1;
    step();
    n_chk++; if (o_instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_issue got=%b exp=1", o_instr_valid); end
    i_stall = 1'b0;
    step();
    i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++; if (o_pc !== 32'h40 || o_imem_req !== 1'b0 || o_retired !== 32'd7) begin n_fail++; $display("FAIL bp_exec%0d got=%h/%b/%0d exp=40/0/7", c, o_pc, o_imem_req, o_retired); end
    end
    i_stall = 1'b0;
    step();
    n_chk++; if (o_pc !== 32'h44 || o_imem_req !== 1'b1 || o_retired !== 32'd8) begin n_fail++; $display("FAIL bp_release got=%h/%b/%0d exp=44/1/8", o_pc, o_imem_req, o_retired); end
  endtask

  task automatic test_wrap();
    step(); step();
    i_jump_valid = 1'b1; i_jump_target = 32'hFFFF_FFFC;
    step();
    i_jump_valid = 1'b0;
    n_chk++; if (o_imem_addr !== 32'hFFFF_FFFC || o_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_setup got=%h/%h exp=fffffffc/0", o_imem_addr, o_pc_plus4); end
    step(); step(); step();
    n_chk++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL wrap_addr got=%b/%h/%b exp=1/0/0", o_imem_req, o_imem_addr, o_fault); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_imem_ack = 1'b0;
    for (int c = 1; c < 8; c++) begin
      step();
      n_chk++; if (o_imem_req !== 1'b1 || o_fault !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d got=%b/%b exp=1/0", c, o_imem_req, o_fault); end
    end
    step();
    n_chk++; if (o_fault !== 1'b1 || o_fault_code !== 2'b01 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL to_fault got=%b/%b/%b exp=1/01/0", o_fault, o_fault_code, o_imem_req); end
    i_imem_ack = 1'b1;
    step(); step();
    n_chk++; if (o_fault !== 1'b1 || o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_sticky got=%b/%b/%b exp=1/0/0", o_fault, o_imem_req, o_instr_valid); end
    do_reset();
    i_imem_ack = 1'b0;
    for (int c = 1; c < 8; c++) step();
    i_imem_ack = 1'b1;
    step();
    n_chk++; if (o_fault !== 1'b0 || o_instr_valid !== 1'b1 || o_fault_code !== 2'b00) begin n_fail++; $display("FAIL to_last_ack got=%b/%b/%b exp=0/1/00", o_fault, o_instr_valid, o_fault_code); end
  endtask

  task automatic test_misalign();
    do_reset();
    step(); step();
    i_jump_valid = 1'b1; i_jump_target = 32'h102;
    step();
    i_jump_valid = 1'b0;
    n_chk++; if (o_pc !== 32'h102 || o_fault !== 1'b1 || o_fault_code !== 2'b10) begin n_fail++; $display("FAIL mis_fault got=%h/%b/%b exp=102/1/10", o_pc, o_fault, o_fault_code); end
    n_chk++; if (o_retired !== 32'd1) begin n_fail++; $display("FAIL mis_retired got=%0d exp=1", o_retired); end
    step(); step(); step();
    n_chk++; if (o_imem_req !== 1'b0 || o_pc !== 32'h102) begin n_fail++; $display("FAIL mis_noreq got=%b/%h exp=0/102", o_imem_req, o_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); step(); step();
    step(); step();
    n_chk++; if (o_pc !== 32'h4 || o_retired !== 32'd1 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_pre got=%h/%0d/%b exp=4/1/0", o_pc, o_retired, o_imem_req); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_chk++; if (o_pc !== 32'h0 || o_retired !== 32'd0 || o_imem_req !== 1'b1 || o_instr !== 32'h0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL ar_immediate got=%h/%0d/%b/%h/%b exp=0/0/1/0/0", o_pc, o_retired, o_imem_req, o_instr, o_instr_valid); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n_chk++; if (o_imem_addr !== 32'h0 || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_release got=%h/%b exp=0/1", o_imem_addr, o_imem_req); end
    step();
    n_chk++; if (o_instr_valid !== 1'b1 || o_instr !== 32'hC0DE_0000) begin n_fail++; $display("FAIL ar_refetch got=%b/%h exp=1/c0de0000", o_instr_valid, o_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
